dmem_responder: RTL and testbench

- Data-side memory responder for the 5-stage MIPS core. It is the target end of the core's M-stage load/store interface: address out, write data out, read data in.
- Accepts one word request at a time and inserts a programmable number of wait states. Returns read data or commits a byte-masked write.
- Drives a stall back to the core's hazard unit until the access completes.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_bytearray.sv | 40 ++++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-side memory responder.
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] strbMask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// Word array with per-byte write mask and a registered read port.
module dmem_bytearray
  import dmem_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic              rdZero,
  input  logic [AW-1:0]     idx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] wrMask;

  assign wrMask = strbMask(wstrb);

  // Array contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[idx] <= (mem[idx] & ~wrMask) | (wdata & wrMask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rdZero) begin
      rdata <= '0;
    end else if (rdEn) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage load/store target: one access at a time with WAIT_CYCLES wait states.
// state | meaning
// IDLE  | no access outstanding, accepts req
// BUSY  | counting down wait states
// DONE  | ack (and err if misaligned) for this one cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              stall
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t            state, nextState;
  logic [CNT_W-1:0]  cnt;
  logic              latWe;
  logic [STRB_W-1:0] latStrb;
  logic [AW+1:0]     latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              accept, commit, misaligned;
  logic              cWe;
  logic [STRB_W-1:0] cStrb;
  logic [AW+1:0]     cAddr;
  logic [DATA_W-1:0] cWdata;
  logic              unusedAddr;

  assign unusedAddr = ^addr[31:AW+2];
  assign accept     = (state == IDLE) && req;

  // With no wait states the commit edge is the accept edge, so use the live inputs.
  assign commit = (WAIT_CYCLES == 0) ? accept : ((state == BUSY) && (cnt == 4'd1));
  assign cWe    = (WAIT_CYCLES == 0) ? we : latWe;
  assign cStrb  = (WAIT_CYCLES == 0) ? wstrb : latStrb;
  assign cAddr  = (WAIT_CYCLES == 0) ? addr[AW+1:0] : latAddr;
  assign cWdata = (WAIT_CYCLES == 0) ? wdata : latWdata;
  assign misaligned = |cAddr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      latWe    <= 1'b0;
      latStrb  <= '0;
      latAddr  <= '0;
      latWdata <= '0;
    end else if (accept) begin
      cnt      <= WAIT_LD;
      latWe    <= we;
      latStrb  <= wstrb;
      latAddr  <= addr[AW+1:0];
      latWdata <= wdata;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    nextState = state;
    ack       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (req) nextState = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY: if (cnt == 4'd1) nextState = DONE;
      DONE: begin
        ack       = 1'b1;
        err       = |latAddr[1:0];
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign stall = req & ~ack;

  dmem_bytearray #(.AW(AW)) uArray (
    .clk   (clk),
    .rst   (rst),
    .wrEn  (commit & cWe & ~misaligned),
    .rdEn  (commit & ~cWe & ~misaligned),
    .rdZero(commit & misaligned),
    .idx   (cAddr[AW+1:2]),
    .wstrb (cStrb),
    .wdata (cWdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (2, 3 and 0 wait states) with shared data inputs.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdataV [3];
  logic [2:0]  ackV, errV, stallV;

  int nCmp = 0;
  int nBad = 0;

  int          lat, stalls;
  logic [31:0] rd, r0, r1;
  logic        e, ackSeen;
  logic [5:0]  ackBits, stallBits;

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .rdata(rdataV[0]), .ack(ackV[0]), .err(errV[0]), .stall(stallV[0]));
  dmem_responder #(.AW(10), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .rdata(rdataV[1]), .ack(ackV[1]), .err(errV[1]), .stall(stallV[1]));
  dmem_responder #(.AW(10), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .rdata(rdataV[2]), .ack(ackV[2]), .err(errV[2]), .stall(stallV[2]));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts just after an edge; returns just after the edge that follows the ack cycle.
  task automatic doAccess(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] wd, output int latO, output int stallsO,
                          output logic [31:0] rdO, output logic eO);
    latO = 0; stallsO = 0;
    req[d] = 1'b1; we = w; wstrb = s; addr = a; wdata = wd;
    #1;
    if (stallV[d]) stallsO++;
    while (latO < 40) begin
      @(posedge clk); #1;
      latO++;
      if (ackV[d]) break;
      if (stallV[d]) stallsO++;
    end
    checkVal("ackSeen", ackV[d], 1);
    rdO = rdataV[d];
    eO  = errV[d];
    req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic store(input int d, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic expErr, input string tag);
    int l, st; logic [31:0] r; logic ee;
    doAccess(d, 1'b1, s, a, wd, l, st, r, ee);
    checkVal({tag, "_err"}, ee, expErr);
  endtask

  task automatic load(input int d, input logic [31:0] a, input logic [31:0] expRd,
                      input logic expErr, input string tag);
    int l, st; logic [31:0] r; logic ee;
    doAccess(d, 1'b0, 4'hF, a, 32'h0, l, st, r, ee);
    checkVal({tag, "_rdata"}, r, expRd);
    checkVal({tag, "_err"}, ee, expErr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; we = 1'b0; wstrb = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checkVal("rst_rdata", rdataV[d], 32'h0);
      checkVal("rst_ack", ackV[d], 1'b0);
      checkVal("rst_err", errV[d], 1'b0);
      checkVal("rst_stall", stallV[d], 1'b0);
    end
    req[0] = 1'b1; #1;
    checkVal("rst_stallFollowsReq", stallV[0], 1'b1);
    req[0] = 1'b0; #1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Reset mid-access aborts the store (2 wait states)
    store(0, 32'h20, 4'hF, 32'h1234_5678, 1'b0, "w20");
    load(0, 32'h20, 32'h1234_5678, 1'b0, "r20a");
    req[0] = 1'b1; we = 1'b1; wstrb = 4'hF; addr = 32'h20; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checkVal("abort_rdata", rdataV[0], 32'h0);
    checkVal("abort_stall", stallV[0], 1'b1);
    ackSeen = ackV[0];
    repeat (4) begin @(posedge clk); #1; ackSeen |= ackV[0]; end
    req[0] = 1'b0; #1;
    checkVal("abort_stallDrop", stallV[0], 1'b0);
    @(negedge clk) rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; ackSeen |= ackV[0]; end
    checkVal("abort_noAck", ackSeen, 1'b0);
    load(0, 32'h20, 32'h1234_5678, 1'b0, "r20b");

    // Wait states (3): latency and stall length
    doAccess(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, stalls, rd, e);
    checkVal("w3_storeLat", lat, 4);
    checkVal("w3_storeStall", stalls, 4);
    checkVal("w3_storeErr", e, 1'b0);
    doAccess(1, 1'b0, 4'hF, 32'h10, 32'h0, lat, stalls, rd, e);
    checkVal("w3_loadLat", lat, 4);
    checkVal("w3_loadStall", stalls, 4);
    checkVal("w3_loadData", rd, 32'hDEAD_BEEF);

    // Byte merge, zero strobe, rdata held across stores
    store(1, 32'h14, 4'hF, 32'h1122_3344, 1'b0, "w14");
    checkVal("storeKeepsRdata", rdataV[1], 32'hDEAD_BEEF);
    store(1, 32'h14, 4'b0101, 32'hAABB_CCDD, 1'b0, "merge");
    store(1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 1'b0, "zeroStrb");
    load(1, 32'h14, 32'h11BB_33DD, 1'b0, "mergeRd");

    // Drop req after acceptance: cycle k is the cycle after edge k-1
    req[1] = 1'b1; we = 1'b0; wstrb = 4'hF; addr = 32'h10;
    ackBits = '0; stallBits = '0; rd = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin req[1] = 1'b0; #1; end
      ackBits[k-1]   = ackV[1];
      stallBits[k-1] = stallV[1];
      if (k == 4) rd = rdataV[1];
    end
    checkVal("drop_ackCycle", ackBits, 6'b001000);
    checkVal("drop_stall", stallBits, 6'b000000);
    checkVal("drop_rdata", rd, 32'hDEAD_BEEF);

    // Zero wait states, req held for two loads
    store(2, 32'h8, 4'hF, 32'h0A0B_0C0D, 1'b0, "w08");
    store(2, 32'hC, 4'hF, 32'h0102_0304, 1'b0, "w0c");
    req[2] = 1'b1; we = 1'b0; wstrb = 4'hF; addr = 32'h8;
    ackBits = '0; r0 = '0; r1 = '0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      ackBits[k-1] = ackV[2];
      if (k == 1) begin r0 = rdataV[2]; addr = 32'hC; end
      if (k == 3) begin r1 = rdataV[2]; req[2] = 1'b0; end
    end
    checkVal("b2b_ackPattern", ackBits, 6'b000101);
    checkVal("b2b_rdata0", r0, 32'h0A0B_0C0D);
    checkVal("b2b_rdata1", r1, 32'h0102_0304);

    // Misaligned and aliasing
    load(2, 32'h0000_0013, 32'h0, 1'b1, "mis13");
    store(2, 32'h0000_000E, 4'hF, 32'hFFFF_FFFF, 1'b1, "misSt");
    load(2, 32'hC, 32'h0102_0304, 1'b0, "noMisWr");
    store(2, 32'h0000_1004, 4'hF, 32'h0000_0055, 1'b0, "aliasW");
    load(2, 32'h0000_0004, 32'h0000_0055, 1'b0, "aliasR");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
